// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, total-period helper and RGB332 field widths
// for the VGA scanout block.
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;

   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   localparam int unsigned RGB_R_W = 3;
   localparam int unsigned RGB_G_W = 3;
   localparam int unsigned RGB_B_W = 2;
   localparam int unsigned RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

   // Full line or frame period from its active, porch and sync segments.
   function automatic int unsigned period_total(input int unsigned active,
                                                input int unsigned fp,
                                                input int unsigned sync,
                                                input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   localparam int unsigned H_TOTAL_DEF = period_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int unsigned V_TOTAL_DEF = period_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_word_fifo.sv
// vga_word_fifo: synchronous pixel-word FIFO with occupancy count and flush.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_flush           empties the FIFO this edge (wins over push)
//   i_push/i_push_data write one word
//   i_pop             consume head word (ignored when empty)
//   o_head            word at the head (stale when empty)
//   o_count, o_empty  occupancy
module vga_word_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_full;
   logic w_do_pop;
   logic w_do_push;

   assign o_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_do_pop  = i_pop && !o_empty;
   // A push into a full FIFO is accepted only when a pop frees the slot.
   assign w_do_push = i_push && (!w_full || w_do_pop);
   assign o_head    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush && !reset) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator with framebuffer fetch engine.
// Ports:
//   clk, reset                 pixel clock, synchronous active-high reset
//   enable                     0 forces black, timing and fetch keep running
//   fb_base                    frame start word address, latched at vblank
//   mem_rd_req/mem_rd_addr     one word read per asserted cycle
//   mem_rd_valid/mem_rd_data   in-order responses, [15:8] odd / [7:0] even pixel
//   hsync, vsync               active-low syncs (registered)
//   de, rgb                    active video and RGB332 pixel (registered)
//   vblank_start               one-cycle pulse entering vertical blanking
//   underflow                  sticky: active pixel met an empty FIFO
module vga_scanout
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
   parameter int unsigned H_FP       = H_FP_DEF,
   parameter int unsigned H_SYNC     = H_SYNC_DEF,
   parameter int unsigned H_BP       = H_BP_DEF,
   parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
   parameter int unsigned V_FP       = V_FP_DEF,
   parameter int unsigned V_SYNC     = V_SYNC_DEF,
   parameter int unsigned V_BP       = V_BP_DEF,
   parameter int unsigned ADDR_W     = 22,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] fb_base,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_valid,
   input  logic [15:0]       mem_rd_data,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [RGB_W-1:0]  rgb,
   output logic              vblank_start,
   output logic              underflow
);

   localparam int unsigned H_TOTAL = period_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = period_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned HC_W    = $clog2(H_TOTAL + 1);
   localparam int unsigned VC_W    = $clog2(V_TOTAL + 1);
   localparam int unsigned WORDS   = H_ACTIVE * V_ACTIVE / 2;
   localparam int unsigned WC_W    = $clog2(WORDS + 1);
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OC_W    = CNT_W + 1;

   localparam logic [HC_W-1:0] H_LAST    = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0] H_ACT_C   = HC_W'(H_ACTIVE);
   localparam logic [HC_W-1:0] H_SYNC_LO = HC_W'(H_ACTIVE + H_FP);
   localparam logic [HC_W-1:0] H_SYNC_HI = HC_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VC_W-1:0] V_LAST    = VC_W'(V_TOTAL - 1);
   localparam logic [VC_W-1:0] V_ACT_C   = VC_W'(V_ACTIVE);
   localparam logic [VC_W-1:0] V_SYNC_LO = VC_W'(V_ACTIVE + V_FP);
   localparam logic [VC_W-1:0] V_SYNC_HI = VC_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [HC_W-1:0]   r_h_cnt;
   logic [VC_W-1:0]   r_v_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [WC_W-1:0]   r_fetched;
   logic [OC_W-1:0]   r_pend;
   logic [OC_W-1:0]   r_drop;
   logic              r_skip;
   logic              r_hsync, r_vsync, r_de, r_vblank_start, r_underflow;
   logic [RGB_W-1:0]  r_rgb;

   logic              w_active, w_flush, w_odd, w_req, w_rsp_live, w_push;
   logic              w_room, w_pix_ok, w_pix_pop, w_hsync_n, w_vsync_n;
   logic [OC_W-1:0]   w_inflight;
   logic [15:0]       w_head;
   logic [CNT_W-1:0]  w_fifo_count;
   logic              w_fifo_empty;
   logic [RGB_W-1:0]  w_pix;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= V_ACT_C;
      end else if (r_h_cnt == H_LAST) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VC_W'(1);
      end else begin
         r_h_cnt <= r_h_cnt + HC_W'(1);
      end
   end

   assign w_active  = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
   assign w_hsync_n = !((r_h_cnt >= H_SYNC_LO) && (r_h_cnt < H_SYNC_HI));
   assign w_vsync_n = !((r_v_cnt >= V_SYNC_LO) && (r_v_cnt < V_SYNC_HI));
   assign w_flush   = (r_h_cnt == '0) && (r_v_cnt == V_ACT_C);
   assign w_odd     = r_h_cnt[0];

   // Fetch engine. r_pend counts requests whose data will be kept; r_drop
   // counts older in-flight requests whose data must be thrown away. Since
   // responses are in order, every response first retires r_drop.
   assign w_room     = (OC_W'(w_fifo_count) + r_pend) < OC_W'(FIFO_DEPTH);
   assign w_req      = !reset && !w_flush && w_room && (r_fetched < WC_W'(WORDS));
   assign w_rsp_live = mem_rd_valid && (r_drop == '0);
   assign w_push     = w_rsp_live && !w_flush;
   assign w_inflight = r_drop + r_pend;

   assign mem_rd_req  = w_req;
   assign mem_rd_addr = r_addr;

   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         // r_drop deliberately survives reset: requests issued before it
         // still come back and must not reach the FIFO.
         r_pend <= '0;
         r_drop <= (mem_rd_valid && (w_inflight != '0)) ? w_inflight - OC_W'(1) : w_inflight;
      end else begin
         r_pend <= r_pend + OC_W'(w_req) - OC_W'(w_rsp_live);
         r_drop <= r_drop - OC_W'(mem_rd_valid && (r_drop != '0));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr    <= '0;
         r_fetched <= '0;
      end else if (w_flush) begin
         r_addr    <= fb_base;
         r_fetched <= '0;
      end else if (w_req) begin
         r_addr    <= r_addr + ADDR_W'(1);
         r_fetched <= r_fetched + WC_W'(1);
      end
   end

   vga_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_flush     (w_flush),
      .i_push      (w_push),
      .i_push_data (mem_rd_data),
      .i_pop       (w_pix_pop),
      .o_head      (w_head),
      .o_count     (w_fifo_count),
      .o_empty     (w_fifo_empty)
   );

   // r_skip remembers that the even half of the current pair underflowed, so
   // the odd half stays black even if its word turns up late. The late word
   // is still popped to keep the following pairs aligned.
   assign w_pix     = w_odd ? w_head[15:8] : w_head[7:0];
   assign w_pix_ok  = w_active && !w_fifo_empty && !(w_odd && r_skip);
   assign w_pix_pop = w_active && w_odd && !w_fifo_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hsync        <= 1'b1;
         r_vsync        <= 1'b1;
         r_de           <= 1'b0;
         r_rgb          <= '0;
         r_vblank_start <= 1'b0;
         r_underflow    <= 1'b0;
         r_skip         <= 1'b0;
      end else begin
         r_hsync        <= w_hsync_n;
         r_vsync        <= w_vsync_n;
         r_de           <= w_active;
         r_rgb          <= (w_pix_ok && enable) ? w_pix : '0;
         r_vblank_start <= w_flush;
         if (w_active && w_fifo_empty) r_underflow <= 1'b1;
         if (w_active && !w_odd)       r_skip      <= w_fifo_empty;
      end
   end

   assign hsync        = r_hsync;
   assign vsync        = r_vsync;
   assign de           = r_de;
   assign rgb          = r_rgb;
   assign vblank_start = r_vblank_start;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;

   localparam int ADDR_W = 22;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b1;
   logic [ADDR_W-1:0] fb_base = '0;
   logic              mem_rd_req;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic              mem_rd_valid = 1'b0;
   logic [15:0]       mem_rd_data = '0;
   logic              hsync, vsync, de, vblank_start, underflow;
   logic [7:0]        rgb;

   vga_scanout #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .ADDR_W(ADDR_W), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .fb_base(fb_base),
      .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
      .vblank_start(vblank_start), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Memory model: 2-cycle latency, word i = {2i+1, 2i} (low 8 bits each).
   logic              s1_v = 1'b0;
   logic [ADDR_W-1:0] s1_a = '0;
   logic              mem_block = 1'b0;
   int                tb_out = 0;

   always @(posedge clk) begin
      s1_v         <= mem_rd_req;
      s1_a         <= mem_rd_addr;
      mem_rd_valid <= s1_v && !mem_block;
      mem_rd_data  <= {8'(2 * s1_a + 1), 8'(2 * s1_a)};
      tb_out       <= tb_out + int'(mem_rd_req) - int'(mem_rd_valid);
   end

   // Scoreboard of expected active pixels, consumed by the monitor.
   logic [7:0] exp_q[$];
   bit         pix_en = 1'b0;

   task automatic push_frame(input int first, input bit black);
      for (int i = 0; i < 32; i++) exp_q.push_back(black ? 8'h00 : 8'(first + i));
   endtask

   int         cyc = 0;
   int         last_vb = -1;
   int         de_run = 0, de_runs = 0, hs_run = 0, vs_run = 0;
   int         last_de_rise = -1000;
   logic       de_q = 1'b0, hs_q = 1'b1, vs_q = 1'b1, vb_q = 1'b0;
   logic [7:0] e;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         last_vb = -1; de_run = 0; de_runs = 0; hs_run = 0; vs_run = 0;
         last_de_rise = -1000; de_q = 1'b0; hs_q = 1'b1; vs_q = 1'b1; vb_q = 1'b0;
      end else begin
         if (de && pix_en) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL pixel_unexpected: got rgb=%0d, expected no active pixel", rgb);
            end else begin
               e = exp_q.pop_front();
               check("pixel", 32'(rgb), 32'(e));
            end
         end
         if (de) begin
            if (!de_q) last_de_rise = cyc;
            de_run++;
         end else if (de_q) begin
            check("de_run_len", de_run, 8);
            de_run = 0;
            de_runs++;
         end
         if (!hsync) begin
            if (hs_q && (cyc - last_de_rise < 14)) check("hsync_after_de", cyc - last_de_rise, 10);
            hs_run++;
         end else if (!hs_q) begin
            check("hsync_len", hs_run, 2);
            hs_run = 0;
         end
         if (!vsync) vs_run++;
         else if (!vs_q) begin
            check("vsync_len", vs_run, 14);
            vs_run = 0;
         end
         if (vb_q) check("vblank_width", 32'(vblank_start), 0);
         if (vblank_start) begin
            if (last_vb >= 0) begin
               check("vblank_period", cyc - last_vb, 98);
               check("de_lines", de_runs, 4);
            end
            last_vb = cyc;
            de_runs = 0;
         end
         de_q = de; hs_q = hsync; vs_q = vsync; vb_q = vblank_start;
      end
   end

   task automatic wait_vb(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!vblank_start && n < 200);
      if (!vblank_start) begin
         checks++; failures++;
         $display("FAIL %s: got no vblank_start, expected one within 200 cycles", tag);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_hsync"}, 32'(hsync), 1);
      check({tag, "_vsync"}, 32'(vsync), 1);
      check({tag, "_de"}, 32'(de), 0);
      check({tag, "_rgb"}, 32'(rgb), 0);
      check({tag, "_vblank"}, 32'(vblank_start), 0);
      check({tag, "_underflow"}, 32'(underflow), 0);
      check({tag, "_req"}, 32'(mem_rd_req), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      push_frame(0, 1'b0);
      pix_en = 1'b1;
      reset = 1'b0;

      wait_vb("vb1");                        // F1: 0..31
      wait_vb("vb2");
      check("f1_underflow", 32'(underflow), 0);
      push_frame(0, 1'b0);                   // F2 unchanged by mid-frame base change
      repeat (60) @(negedge clk);
      fb_base = 22'd100;
      push_frame(200, 1'b0);                 // F3 starts at word 100
      wait_vb("vb3");
      fb_base = '0;
      wait_vb("vb4");
      enable = 1'b0;
      push_frame(0, 1'b1);                   // F4 black
      wait_vb("vb5");
      enable = 1'b1;
      push_frame(0, 1'b0);                   // F5 restarts at 0
      wait_vb("vb6");
      check("queue_drained_f5", exp_q.size(), 0);

      n = 0;
      while (tb_out != 2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("outstanding_before_reset", tb_out, 2);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("mid");
      reset = 1'b0;
      push_frame(0, 1'b0);                   // first frame after reset
      wait_vb("vb7");
      wait_vb("vb8");
      check("f7_underflow", 32'(underflow), 0);
      check("queue_drained_f7", exp_q.size(), 0);

      mem_block = 1'b1;
      push_frame(0, 1'b1);                   // starved frame is black
      wait_vb("vb9");
      check("starved_underflow", 32'(underflow), 1);
      check("queue_drained_f8", exp_q.size(), 0);
      pix_en = 1'b0;
      mem_block = 1'b0;
      wait_vb("vb10");
      check("underflow_sticky", 32'(underflow), 1);
      reset = 1'b1;
      @(negedge clk);
      check("underflow_cleared", 32'(underflow), 0);
      check("final_de", 32'(de), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
